// File: rtl/prog_fetch.sv
// Instruction fetch for a 16-bit-word program memory. It assembles one- and two-word
// instructions, hands them to the decoder, and slots LPM data reads into idle fetch cycles.
module prog_fetch #(
    parameter int              PC_W      = 14,
    parameter logic [PC_W-1:0] RESET_VEC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic [PC_W-1:0] pm_addr,
    input  logic [15:0]     pm_dout,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            lpm_req,
    input  logic [PC_W-1:0] lpm_addr,
    output logic [15:0]     lpm_data,
    output logic            lpm_ack,
    output logic            ins_valid,
    input  logic            ins_ready,
    output logic [15:0]     ins_word0,
    output logic [15:0]     ins_word1,
    output logic            ins_two,
    output logic [PC_W-1:0] ins_pc
);

    typedef enum logic [2:0] {A0, D0, D1, OUT, LD} state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     word0_q, word1_q;
    logic            two_q;
    logic [PC_W-1:0] ins_pc_q;
    logic            ret_out_q, ret_out_d;
    logic            cap0, cap1;

    // LDS/STS (0x9000/0x9200) and JMP/CALL (0x940C/0x940E) carry a second word.
    function automatic logic is_two_word(input logic [15:0] w);
        return ((w & 16'hFE0F) == 16'h9000) || ((w & 16'hFE0F) == 16'h9200) ||
               ((w & 16'hFE0E) == 16'h940C) || ((w & 16'hFE0E) == 16'h940E);
    endfunction

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pm_addr   = pc_q;
        ret_out_d = ret_out_q;
        cap0      = 1'b0;
        cap1      = 1'b0;
        unique case (state_q)
            A0: begin
                state_d = D0;
                if (lpm_req) begin
                    pm_addr   = lpm_addr;
                    state_d   = LD;
                    ret_out_d = 1'b0;
                end
            end
            D0: begin
                cap0    = 1'b1;
                pm_addr = pc_q + PC_W'(1);
                state_d = is_two_word(pm_dout) ? D1 : OUT;
            end
            D1: begin
                cap1    = 1'b1;
                state_d = OUT;
            end
            OUT: begin
                if (ins_ready) begin
                    pc_d    = pc_q + (two_q ? PC_W'(2) : PC_W'(1));
                    pm_addr = pc_d;
                    state_d = D0;
                end else if (lpm_req) begin
                    pm_addr   = lpm_addr;
                    state_d   = LD;
                    ret_out_d = 1'b1;
                end
            end
            LD:      state_d = ret_out_q ? OUT : A0;
            default: state_d = A0;
        endcase
        // Redirect overrides everything, including an in-progress transfer.
        if (redirect) begin
            pc_d    = redirect_pc;
            pm_addr = redirect_pc;
            state_d = D0;
            cap0    = 1'b0;
            cap1    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= A0;
            pc_q      <= RESET_VEC;
            word0_q   <= '0;
            word1_q   <= '0;
            two_q     <= 1'b0;
            ins_pc_q  <= '0;
            ret_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ret_out_q <= ret_out_d;
            if (cap0) begin
                word0_q  <= pm_dout;
                word1_q  <= '0;
                two_q    <= 1'b0;
                ins_pc_q <= pc_q;
            end
            if (cap1) begin
                word1_q <= pm_dout;
                two_q   <= 1'b1;
            end
        end
    end

    assign ins_valid = (state_q == OUT);
    assign ins_word0 = word0_q;
    assign ins_word1 = word1_q;
    assign ins_two   = two_q;
    assign ins_pc    = ins_pc_q;
    assign lpm_ack   = (state_q == LD);
    assign lpm_data  = lpm_ack ? pm_dout : 16'h0000;

endmodule

// File: tb/tb_prog_fetch.sv
module tb_prog_fetch;
  localparam int PC_W = 14;

  logic            clk = 1'b0;
  logic            rst;
  logic [PC_W-1:0] pm_addr;
  logic [15:0]     pm_dout;
  logic            redirect;
  logic [PC_W-1:0] redirect_pc;
  logic            lpm_req;
  logic [PC_W-1:0] lpm_addr;
  logic [15:0]     lpm_data;
  logic            lpm_ack;
  logic            ins_valid;
  logic            ins_ready;
  logic [15:0]     ins_word0;
  logic [15:0]     ins_word1;
  logic            ins_two;
  logic [PC_W-1:0] ins_pc;

  logic [15:0] mem [0:(1<<PC_W)-1];
  int n_run  = 0;
  int n_fail = 0;

  prog_fetch #(.PC_W(PC_W), .RESET_VEC('0)) dut (
    .clk(clk), .rst(rst), .pm_addr(pm_addr), .pm_dout(pm_dout),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .lpm_req(lpm_req), .lpm_addr(lpm_addr), .lpm_data(lpm_data), .lpm_ack(lpm_ack),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_word0(ins_word0),
    .ins_word1(ins_word1), .ins_two(ins_two), .ins_pc(ins_pc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) pm_dout <= mem[pm_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fail(input string tag);
    n_fail++;
    $error("FAIL %s", tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << PC_W); i++) mem[i] = 16'h0000;
    mem[0]      = 16'hE221;
    mem[1]      = 16'hE304;
    mem[4]      = 16'h9320;
    mem[5]      = 16'h0800;
    mem[6]      = 16'hE000;
    mem[7]      = 16'h940C;
    mem[8]      = 16'hBEEF;
    mem[14'h90] = 16'h932F;
    mem[14'h3FFF] = 16'h940E;
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0;
    lpm_req = 1'b0; lpm_addr = '0; ins_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_pm_addr", pm_addr, 14'h0);
    chk("rst_valid", ins_valid, 1'b0);
    chk("rst_two", ins_two, 1'b0);
    chk("rst_w0", ins_word0, 16'h0);
    chk("rst_w1", ins_word1, 16'h0);
    chk("rst_pc", ins_pc, 14'h0);
    chk("rst_ack", lpm_ack, 1'b0);
    chk("rst_lpm_data", lpm_data, 16'h0);

    rst = 1'b0; #1;
    chk("c0_pm_addr", pm_addr, 14'h0);
    chk("c0_valid", ins_valid, 1'b0);
    tick();
    chk("c1_valid", ins_valid, 1'b0);
    chk("c1_pm_addr", pm_addr, 14'h1);
    tick();
    chk("c2_valid", ins_valid, 1'b1);
    chk("c2_w0", ins_word0, 16'hE221);
    chk("c2_pc", ins_pc, 14'h0);
    chk("c2_two", ins_two, 1'b0);
    chk("c2_w1", ins_word1, 16'h0);
    chk("c2_pm_addr", pm_addr, 14'h1);
    tick();
    chk("c3_valid", ins_valid, 1'b0);
    tick();
    chk("c4_valid", ins_valid, 1'b1);
    chk("c4_pc", ins_pc, 14'h1);
    chk("c4_w0", ins_word0, 16'hE304);
    repeat (4) tick();
    chk("c8_valid", ins_valid, 1'b1);
    chk("c8_pc", ins_pc, 14'h3);

    tick();
    tick();
    chk("sts_d1_valid", ins_valid, 1'b0);
    tick();
    chk("sts_valid", ins_valid, 1'b1);
    chk("sts_two", ins_two, 1'b1);
    chk("sts_w0", ins_word0, 16'h9320);
    chk("sts_w1", ins_word1, 16'h0800);
    chk("sts_pc", ins_pc, 14'h4);

    ins_ready = 1'b0; #1;
    chk("hold_pm_addr0", pm_addr, 14'h4);
    for (int k = 0; k < 5; k++) begin
      tick();
      n_run += 4;
      if (ins_valid !== 1'b1) fail("hold_valid");
      if (ins_pc !== 14'h4) fail("hold_pc");
      if (ins_word1 !== 16'h0800) fail("hold_w1");
      if (pm_addr !== 14'h4) fail("hold_pm_addr");
    end
    ins_ready = 1'b1; #1;
    chk("xfer2_pm_addr", pm_addr, 14'h6);
    tick();
    chk("after_xfer_valid", ins_valid, 1'b0);
    tick();
    chk("i6_valid", ins_valid, 1'b1);
    chk("i6_pc", ins_pc, 14'h6);
    chk("i6_w0", ins_word0, 16'hE000);
    chk("i6_two", ins_two, 1'b0);

    ins_ready = 1'b0; lpm_req = 1'b1; lpm_addr = 14'h8; #1;
    chk("lpm_pm_addr", pm_addr, 14'h8);
    chk("lpm_ack_early", lpm_ack, 1'b0);
    tick();
    lpm_req = 1'b0;
    chk("lpm_ack", lpm_ack, 1'b1);
    chk("lpm_data", lpm_data, 16'hBEEF);
    chk("lpm_valid", ins_valid, 1'b0);
    chk("lpm_w0_kept", ins_word0, 16'hE000);
    chk("lpm_pc_kept", ins_pc, 14'h6);
    tick();
    chk("lpm_ret_valid", ins_valid, 1'b1);
    chk("lpm_ret_pc", ins_pc, 14'h6);
    chk("lpm_ack_once", lpm_ack, 1'b0);

    ins_ready = 1'b1; #1;
    chk("i7_pm_addr", pm_addr, 14'h7);
    tick();
    chk("jmp_d0_pm_addr", pm_addr, 14'h8);
    tick();
    redirect = 1'b1; redirect_pc = 14'h90; #1;
    chk("redir_pm_addr", pm_addr, 14'h90);
    tick();
    redirect = 1'b0;
    chk("redir_valid", ins_valid, 1'b0);
    tick();
    chk("r90_valid", ins_valid, 1'b1);
    chk("r90_pc", ins_pc, 14'h90);
    chk("r90_w0", ins_word0, 16'h932F);
    chk("r90_two", ins_two, 1'b0);

    mem[0] = 16'h0090;
    redirect = 1'b1; redirect_pc = 14'h3FFF; #1;
    chk("redir_beats_xfer", pm_addr, 14'h3FFF);
    tick();
    redirect = 1'b0; #1;
    chk("wrap_pm_addr", pm_addr, 14'h0);
    chk("wrap_valid", ins_valid, 1'b0);
    tick();
    tick();
    chk("call_valid", ins_valid, 1'b1);
    chk("call_two", ins_two, 1'b1);
    chk("call_w0", ins_word0, 16'h940E);
    chk("call_w1", ins_word1, 16'h0090);
    chk("call_pc", ins_pc, 14'h3FFF);
    chk("call_next_addr", pm_addr, 14'h1);
    tick();
    tick();
    chk("after_call_pc", ins_pc, 14'h1);
    chk("after_call_valid", ins_valid, 1'b1);

    ins_ready = 1'b0; lpm_req = 1'b1; lpm_addr = 14'h8;
    tick();
    lpm_req = 1'b0; redirect = 1'b1; redirect_pc = 14'h90; #1;
    chk("ld_redir_ack", lpm_ack, 1'b1);
    chk("ld_redir_data", lpm_data, 16'hBEEF);
    chk("ld_redir_pm_addr", pm_addr, 14'h90);
    tick();
    redirect = 1'b0;
    chk("ld_redir_valid", ins_valid, 1'b0);
    chk("ld_redir_ack_off", lpm_ack, 1'b0);
    tick();
    chk("ld_redir_pc", ins_pc, 14'h90);
    chk("ld_redir_valid2", ins_valid, 1'b1);

    lpm_req = 1'b1; lpm_addr = 14'h8;
    tick();
    lpm_req = 1'b0; rst = 1'b1; #1;
    chk("abort_ack", lpm_ack, 1'b0);
    chk("abort_pm_addr", pm_addr, 14'h0);
    chk("abort_valid", ins_valid, 1'b0);
    chk("abort_pc", ins_pc, 14'h0);

    tick();
    rst = 1'b0; lpm_req = 1'b1; lpm_addr = 14'h8; #1;
    chk("a0_lpm_pm_addr", pm_addr, 14'h8);
    tick();
    lpm_req = 1'b0;
    chk("a0_lpm_ack", lpm_ack, 1'b1);
    chk("a0_lpm_data", lpm_data, 16'hBEEF);
    chk("a0_lpm_valid", ins_valid, 1'b0);
    tick();
    chk("a0_ret_pm_addr", pm_addr, 14'h0);
    chk("a0_ret_ack", lpm_ack, 1'b0);
    ins_ready = 1'b1;
    tick();
    tick();
    chk("a0_ret_valid", ins_valid, 1'b1);
    chk("a0_ret_pc", ins_pc, 14'h0);
    chk("a0_ret_w0", ins_word0, 16'h0090);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/prog_fetch.md
PROG_FETCH -- requirements
Module: prog_fetch

Interface
REQ-001 SHALL have parameter PC_W, default 14, program-memory word-address width.
REQ-002 SHALL have parameter RESET_VEC, default 0, first fetch word address after reset.
REQ-003 SHALL have one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock, shared with program memory.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 pm_addr  output  PC_W  word address to program memory; combinational from state/pc/redirect/lpm inputs.
REQ-007 pm_dout  input  16  program-memory read data; word for pm_addr presented in cycle N is valid in cycle N+1.
REQ-008 redirect  input  1  one-cycle pulse: discard current fetch, restart at redirect_pc.
REQ-009 redirect_pc  input  PC_W  redirect target word address.
REQ-010 lpm_req  input  1  data read of program memory; held with stable lpm_addr until lpm_ack.
REQ-011 lpm_addr  input  PC_W  LPM word address.
REQ-012 lpm_data  output  16  LPM read word; valid when lpm_ack=1.
REQ-013 lpm_ack  output  1  one-cycle LPM completion strobe.
REQ-014 ins_valid  output  1  instruction payload valid.
REQ-015 ins_ready  input  1  decoder accepts instruction.
REQ-016 ins_word0  output  16  opcode word.
REQ-017 ins_word1  output  16  second word (0 when ins_two=0).
REQ-018 ins_two  output  1  instruction is two words.
REQ-019 ins_pc  output  PC_W  word address of ins_word0.

Function
REQ-020 SHALL implement states A0 (issue pc), D0 (word0 arriving), D1 (word1 arriving), OUT (instruction held), LD (LPM data arriving).
REQ-021 A0: pm_addr=pc; next D0 (unless LPM accepted, REQ-028).
REQ-022 D0: capture pm_dout as word0; pm_addr=pc+1; two-word -> D1, else -> OUT with ins_two=0, ins_word1=0.
REQ-023 Two-word decode: (w&0xFE0F)==0x9000 LDS, ==0x9200 STS; (w&0xFE0E)==0x940C JMP, ==0x940E CALL; all other encodings one word.
REQ-024 D1: capture pm_dout as word1, ins_two=1; next OUT.
REQ-025 OUT: ins_valid=1; transfer on ins_valid&&ins_ready; on transfer pc<=pc+1 (or +2 if ins_two), pm_addr=that new pc same cycle, next D0 (back-to-back; one-word throughput 1 instruction / 2 cycles).
REQ-026 Without transfer, OUT SHALL hold ins_* payload and pc stable.
REQ-027 PC arithmetic SHALL be modulo 2^PC_W; second word of an instruction at 2^PC_W-1 fetched from address 0.
REQ-028 LPM accepted only in A0, or OUT without transfer; pm_addr=lpm_addr, next LD; lpm_req in D0/D1/LD waits.
REQ-029 LD: lpm_data=pm_dout, lpm_ack=1; ins_valid=0 with payload registers unchanged; return to A0 or OUT (state at acceptance).
REQ-030 Priority per cycle: redirect > transfer > LPM acceptance.
REQ-031 Redirect in any state: pc<=redirect_pc, pm_addr=redirect_pc same cycle, next D0; ins_valid=0 next cycle; in-flight word0/word1 discarded; no transfer that cycle.
REQ-032 Redirect in LD SHALL still complete the LPM (lpm_ack=1 that cycle) and drop the return to OUT.
REQ-033 ins_pc SHALL equal pc of the held instruction; lpm_ack never asserted two consecutive cycles.

Reset
REQ-034 While rst=1: state A0, pc=RESET_VEC, pm_addr=RESET_VEC, ins_valid=0, ins_two=0, ins_word0=ins_word1=0, ins_pc=0, lpm_ack=0, lpm_data=0.
REQ-035 rst asserted mid-fetch or mid-LPM SHALL abandon it; no lpm_ack for the aborted LPM.

Verification
REQ-036 mem[0]=0xE221, mem[1]=0xE304, ins_ready=1, release reset -> ins_valid in cycle 2 with word0=0xE221, ins_pc=0, ins_two=0; next ins_valid cycle 4, ins_pc=1.
REQ-037 mem[4]=0x9320, mem[5]=0x0800 -> ins_two=1, word1=0x0800, ins_pc=4; following instruction ins_pc=6.
REQ-038 ins_ready=0 for 5 cycles in OUT -> ins_valid=1, payload and pm-requested pc unchanged; ins_ready=1 -> single transfer.
REQ-039 redirect to 0x0090 while in D1, mem[0x90]=0x932F -> old instruction never valid; next ins_pc=0x0090, word0=0x932F.
REQ-040 LPM lpm_addr=0x0008 while OUT holds instruction -> lpm_ack one cycle after acceptance, lpm_data=mem[8], ins_valid=0 that cycle, same payload valid again next cycle.
REQ-041 CALL 0x940E at 0x3FFF, mem[0]=0x0090 -> word1=0x0090, ins_two=1; next ins_pc=0x0001.
